// File: rtl/vortex_mem_axi_ctrl_if.sv
// AXI4 slave channels plus the word-addressed memory port of vortex_mem_axi_ctrl.
// Width defaults fall back to local values when the VORTEX_AXI_MEM_* macros are not supplied.
`ifndef VORTEX_AXI_MEM_ID_WIDTH
`define VORTEX_AXI_MEM_ID_WIDTH 8
`endif
`ifndef VORTEX_AXI_MEM_ADDR_WIDTH
`define VORTEX_AXI_MEM_ADDR_WIDTH 32
`endif
`ifndef VORTEX_AXI_MEM_DATA_WIDTH
`define VORTEX_AXI_MEM_DATA_WIDTH 512
`endif

interface vortex_mem_axi_ctrl_if #(
  parameter int ID_WIDTH   = `VORTEX_AXI_MEM_ID_WIDTH,
  parameter int ADDR_WIDTH = `VORTEX_AXI_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = `VORTEX_AXI_MEM_DATA_WIDTH
);
  logic                  s_awvalid;
  logic                  s_awready;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic [ID_WIDTH-1:0]   s_awid;
  logic [7:0]            s_awlen;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic                  s_wlast;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [ID_WIDTH-1:0]   s_bid;
  logic [1:0]            s_bresp;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic [ID_WIDTH-1:0]   s_arid;
  logic [7:0]            s_arlen;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [ID_WIDTH-1:0]   s_rid;
  logic                  s_rlast;
  logic [1:0]            s_rresp;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Controller side: AXI slave toward the bus, master toward the memory.
  modport slave (
    input  s_awvalid, s_awaddr, s_awid, s_awlen,
    output s_awready,
    input  s_wvalid, s_wdata, s_wlast,
    output s_wready,
    output s_bvalid, s_bid, s_bresp,
    input  s_bready,
    input  s_arvalid, s_araddr, s_arid, s_arlen,
    output s_arready,
    output s_rvalid, s_rdata, s_rid, s_rlast, s_rresp,
    input  s_rready,
    output mem_addr, mem_wr, mem_rd, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output s_awvalid, s_awaddr, s_awid, s_awlen,
    input  s_awready,
    output s_wvalid, s_wdata, s_wlast,
    input  s_wready,
    input  s_bvalid, s_bid, s_bresp,
    output s_bready,
    output s_arvalid, s_araddr, s_arid, s_arlen,
    input  s_arready,
    input  s_rvalid, s_rdata, s_rid, s_rlast, s_rresp,
    output s_rready,
    input  mem_addr, mem_wr, mem_rd, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/vortex_mem_axi_ctrl.sv
// Single-outstanding AXI4 INCR burst slave in front of a word-addressed memory.
// Define VORTEX_MEM_CTRL_RR_EN for round-robin AW/AR arbitration; otherwise writes win ties.
`ifndef VORTEX_AXI_MEM_ID_WIDTH
`define VORTEX_AXI_MEM_ID_WIDTH 8
`endif
`ifndef VORTEX_AXI_MEM_ADDR_WIDTH
`define VORTEX_AXI_MEM_ADDR_WIDTH 32
`endif
`ifndef VORTEX_AXI_MEM_DATA_WIDTH
`define VORTEX_AXI_MEM_DATA_WIDTH 512
`endif

module vortex_mem_axi_ctrl #(
  parameter int ID_WIDTH   = `VORTEX_AXI_MEM_ID_WIDTH,
  parameter int ADDR_WIDTH = `VORTEX_AXI_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = `VORTEX_AXI_MEM_DATA_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  vortex_mem_axi_ctrl_if.slave bus
);
  localparam int SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_err;
  logic                  w_idle;
  logic                  w_grantW;
  logic                  w_grantR;
  logic                  w_awHs;
  logic                  w_arHs;
  logic                  w_wBeat;
  logic                  w_rBeat;
  logic                  w_lastBeat;

  // Readies are masked while rst is held so the async reset values appear at once.
  assign w_idle     = (r_state == IDLE) && !rst;
  assign w_lastBeat = (r_cnt == r_len);

`ifdef VORTEX_MEM_CTRL_RR_EN
  logic r_lastGrantRead;

  assign w_grantW = bus.s_awvalid && (!bus.s_arvalid || r_lastGrantRead);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_lastGrantRead <= 1'b1;
    else if (w_awHs) r_lastGrantRead <= 1'b0;
    else if (w_arHs) r_lastGrantRead <= 1'b1;
  end
`else
  assign w_grantW = bus.s_awvalid;
`endif

  assign w_grantR = bus.s_arvalid && !w_grantW;
  assign w_awHs   = w_idle && w_grantW;
  assign w_arHs   = w_idle && w_grantR;
  assign w_wBeat  = (r_state == WRITE) && bus.s_wvalid;
  assign w_rBeat  = (r_state == READ) && bus.s_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_awHs) w_next = WRITE;
               else if (w_arHs) w_next = READ;
      WRITE:   if (w_wBeat && w_lastBeat) w_next = WRESP;
      WRESP:   if (bus.s_bready) w_next = IDLE;
      READ:    if (w_rBeat && w_lastBeat) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The beat counter, not wlast, terminates a write burst; wlast only flags an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id   <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_addr <= '0;
      r_err  <= 1'b0;
    end else if (w_awHs) begin
      r_id   <= bus.s_awid;
      r_len  <= bus.s_awlen;
      r_cnt  <= '0;
      r_addr <= bus.s_awaddr >> SHIFT;
      r_err  <= 1'b0;
    end else if (w_arHs) begin
      r_id   <= bus.s_arid;
      r_len  <= bus.s_arlen;
      r_cnt  <= '0;
      r_addr <= bus.s_araddr >> SHIFT;
    end else if (w_wBeat || (w_rBeat && !w_lastBeat)) begin
      r_addr <= r_addr + ADDR_WIDTH'(1);
      r_cnt  <= r_cnt + 8'd1;
      if (w_wBeat && (bus.s_wlast != w_lastBeat)) r_err <= 1'b1;
    end
  end

  always_comb begin
    bus.s_awready = 1'b0;
    bus.s_arready = 1'b0;
    bus.s_wready  = 1'b0;
    bus.s_bvalid  = 1'b0;
    bus.s_bresp   = 2'b00;
    bus.s_bid     = r_id;
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = '0;
    bus.s_rid     = r_id;
    bus.s_rlast   = 1'b0;
    bus.s_rresp   = 2'b00;
    bus.mem_addr  = r_addr;
    bus.mem_wr    = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wdata = '0;
    unique case (r_state)
      IDLE: begin
        bus.s_awready = w_awHs;
        bus.s_arready = w_arHs;
      end
      WRITE: begin
        bus.s_wready  = 1'b1;
        bus.mem_wr    = bus.s_wvalid;
        bus.mem_wdata = bus.s_wdata;
      end
      WRESP: begin
        bus.s_bvalid = 1'b1;
        bus.s_bresp  = r_err ? 2'b10 : 2'b00;
      end
      READ: begin
        bus.s_rvalid = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.s_rdata  = bus.mem_rdata;
        bus.s_rlast  = w_lastBeat;
      end
      default: ;
    endcase
  end
endmodule
